// File: rtl/serial_add_sched.sv
// Round-robin scheduler for a shared external 1-bit full-adder slice.
// Accepts an operand pair from one of two requesters, adds it LSB-first over WIDTH cycles, and returns the tagged sum.
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_ci,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_co,
  output logic             res_id,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] xsr_q, xsr_d;
  logic [WIDTH-1:0] ysr_q, ysr_d;
  logic [WIDTH-1:0] ssr_q, ssr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             grant0, grant1;

  // On contention the requester that was not served last wins.
  assign grant0     = req0_valid & (~req1_valid | last_grant_q);
  assign grant1     = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    xsr_d        = xsr_q;
    ysr_d        = ysr_q;
    ssr_d        = ssr_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready) begin
          xsr_d        = req0_x;
          ysr_d        = req0_y;
          carry_d      = req0_ci;
          cnt_d        = '0;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = SHIFT;
        end else if (req1_ready) begin
          xsr_d        = req1_x;
          ysr_d        = req1_y;
          carry_d      = req1_ci;
          cnt_d        = '0;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        carry_d = fa_co;
        ssr_d   = {fa_s, ssr_q[WIDTH-1:1]};
        xsr_d   = xsr_q >> 1;
        ysr_d   = ysr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      xsr_q        <= '0;
      ysr_q        <= '0;
      ssr_q        <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
      state_q      <= state_d;
      xsr_q        <= xsr_d;
      ysr_q        <= ysr_d;
      ssr_q        <= ssr_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Slice inputs and result port are forced to zero outside the states that own them.
  assign fa_a      = (state_q == SHIFT) & xsr_q[0];
  assign fa_b      = (state_q == SHIFT) & ysr_q[0];
  assign fa_ci     = (state_q == SHIFT) & carry_q;
  assign res_valid = (state_q == DONE);
  assign res_s     = (state_q == DONE) ? ssr_q : '0;
  assign res_co    = (state_q == DONE) & carry_q;
  assign res_id    = (state_q == DONE) & id_q;
  assign busy      = (state_q != IDLE);

endmodule
